// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline hazard stall/flush controller with EX operand hold
//
// Purpose:
//   Detects load-use hazards, holds the pipeline while a multi-cycle EX unit
//   is busy, flushes IF/ID and ID/EX on a taken branch, and captures the
//   forwarded EX operands seen while the pipeline is stalled.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   IF_ID_rs1, IF_ID_rs2     source registers of the instruction in ID
//   ID_EX_rd, ID_EX_memread  destination / load flag of the instruction in EX
//   EX_busy                  multi-cycle EX unit still working
//   EX_branch_taken          redirect resolved in EX this cycle
//   fwd_rsN_data/enable      forwarding results available during a stall
//   PC_stall, IF_ID_stall    freeze fetch and the IF/ID register
//   EX_stall                 freeze EX while the multi-cycle unit is busy
//   ID_EX_bubble             insert a bubble into ID/EX (load-use)
//   IF_ID_flush, ID_EX_flush squash wrong-path instructions
//   hold_rsN_data/valid      first forwarded operand captured during a stall
//   stall_cycles             count of stalled cycles (saturating)
//
// Configuration:
//   HAZARD_STALL_CNT_EN      when defined, stall_cycles counts edges with
//                            PC_stall=1, saturating at 16'hFFFF; otherwise
//                            stall_cycles is tied to zero.

module hazard_stall_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_memread,
    input  logic        EX_busy,
    input  logic        EX_branch_taken,
    input  logic [31:0] fwd_rs1_data,
    input  logic [31:0] fwd_rs2_data,
    input  logic        fwd_rs1_enable,
    input  logic        fwd_rs2_enable,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        EX_stall,
    output logic        ID_EX_bubble,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic [31:0] hold_rs1_data,
    output logic [31:0] hold_rs2_data,
    output logic        hold_rs1_valid,
    output logic        hold_rs2_valid,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        EX_WAIT   = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    state_t state;

    logic load_use;
    logic ex_stall_int;
    logic bubble_int;
    logic flush_int;
    logic stall_int;

    always_comb begin
        load_use     = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                       ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
        // EX holds whenever the unit is busy, except in the one-cycle flush
        // slot where the wrong-path work is being discarded anyway.
        ex_stall_int = EX_busy && (state != FLUSH);
        bubble_int   = load_use && (state == RUN) && !EX_busy && !EX_branch_taken;
        flush_int    = (EX_branch_taken && !ex_stall_int) || (state == FLUSH);
        // A flush always wins over a stall so the redirect is never frozen.
        stall_int    = (ex_stall_int || bubble_int) && !flush_int;
    end

    // Control outputs are forced low for as long as reset is held, without
    // waiting for a clock edge.
    assign EX_stall     = !rst && ex_stall_int;
    assign ID_EX_bubble = !rst && bubble_int;
    assign PC_stall     = !rst && stall_int;
    assign IF_ID_stall  = !rst && stall_int;
    assign IF_ID_flush  = !rst && flush_int;
    assign ID_EX_flush  = !rst && flush_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN, LU_BUBBLE: begin
                    if (EX_branch_taken)
                        state <= FLUSH;
                    else if (EX_busy)
                        state <= EX_WAIT;
                    else if (load_use && (state == RUN))
                        state <= LU_BUBBLE;
                    else
                        state <= RUN;
                end
                EX_WAIT: begin
                    if (EX_busy)
                        state <= EX_WAIT;
                    else if (EX_branch_taken)
                        state <= FLUSH;
                    else
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Operand capture: the first enabled forward seen during a stall is kept
    // until the stall ends; any cycle without EX_stall empties the holders.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rs1_data  <= 32'd0;
            hold_rs2_data  <= 32'd0;
            hold_rs1_valid <= 1'b0;
            hold_rs2_valid <= 1'b0;
        end else if (!ex_stall_int) begin
            hold_rs1_data  <= 32'd0;
            hold_rs2_data  <= 32'd0;
            hold_rs1_valid <= 1'b0;
            hold_rs2_valid <= 1'b0;
        end else begin
            if (fwd_rs1_enable && !hold_rs1_valid) begin
                hold_rs1_data  <= fwd_rs1_data;
                hold_rs1_valid <= 1'b1;
            end
            if (fwd_rs2_enable && !hold_rs2_valid) begin
                hold_rs2_data  <= fwd_rs2_data;
                hold_rs2_valid <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (stall_int && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - randomized and directed checks of hazard_stall_controller against a behavioural model

module tb_hazard_stall_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic        ID_EX_memread, EX_busy, EX_branch_taken;
    logic [31:0] fwd_rs1_data, fwd_rs2_data;
    logic        fwd_rs1_enable, fwd_rs2_enable;
    logic        PC_stall, IF_ID_stall, EX_stall, ID_EX_bubble, IF_ID_flush, ID_EX_flush;
    logic [31:0] hold_rs1_data, hold_rs2_data;
    logic        hold_rs1_valid, hold_rs2_valid;
    logic [15:0] stall_cycles;

    hazard_stall_controller dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_memread(ID_EX_memread),
        .EX_busy(EX_busy), .EX_branch_taken(EX_branch_taken),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs2_enable(fwd_rs2_enable),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .EX_stall(EX_stall),
        .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .hold_rs1_data(hold_rs1_data), .hold_rs2_data(hold_rs2_data),
        .hold_rs1_valid(hold_rs1_valid), .hold_rs2_valid(hold_rs2_valid),
        .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
    localparam int LONG_RUN = 70000;
`else
    localparam bit CNT_ON = 1'b0;
    localparam int LONG_RUN = 500;
`endif

    localparam int M_RUN = 0, M_LU = 1, M_WAIT = 2, M_FLUSH = 3;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_mode;
    logic [31:0] m_h1, m_h2;
    bit          m_v1, m_v2;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RUN;
        m_h1 = 0; m_h2 = 0; m_v1 = 0; m_v2 = 0;
        m_cnt = 0;
    endtask

    function automatic bit f_load_use();
        return ID_EX_memread && ID_EX_rd != 0 &&
               (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
    endfunction

    // Expected combinational outputs for the current model mode and inputs.
    task automatic model_outputs(output bit exs, output bit bub, output bit fl, output bit pcs);
        exs = EX_busy && m_mode != M_FLUSH;
        bub = f_load_use() && m_mode == M_RUN && !EX_busy && !EX_branch_taken;
        fl  = (EX_branch_taken && !exs) || m_mode == M_FLUSH;
        pcs = (exs || bub) && !fl;
    endtask

    task automatic compare_model();
        bit exs, bub, fl, pcs;
        model_outputs(exs, bub, fl, pcs);
        check("EX_stall",       EX_stall,       exs);
        check("ID_EX_bubble",   ID_EX_bubble,   bub);
        check("IF_ID_flush",    IF_ID_flush,    fl);
        check("ID_EX_flush",    ID_EX_flush,    fl);
        check("PC_stall",       PC_stall,       pcs);
        check("IF_ID_stall",    IF_ID_stall,    pcs);
        check("hold_rs1_valid", hold_rs1_valid, m_v1);
        check("hold_rs2_valid", hold_rs2_valid, m_v2);
        check("hold_rs1_data",  hold_rs1_data,  m_h1);
        check("hold_rs2_data",  hold_rs2_data,  m_h2);
        check("stall_cycles",   stall_cycles,   CNT_ON ? m_cnt : 0);
    endtask

    task automatic model_advance();
        bit exs, bub, fl, pcs;
        int nxt;
        model_outputs(exs, bub, fl, pcs);
        if (!exs) begin
            m_h1 = 0; m_h2 = 0; m_v1 = 0; m_v2 = 0;
        end else begin
            if (fwd_rs1_enable && !m_v1) begin m_h1 = fwd_rs1_data; m_v1 = 1; end
            if (fwd_rs2_enable && !m_v2) begin m_h2 = fwd_rs2_data; m_v2 = 1; end
        end
        if (pcs && m_cnt < 65535) m_cnt++;
        nxt = M_RUN;
        if (m_mode == M_FLUSH)           nxt = M_RUN;
        else if (m_mode == M_WAIT)       nxt = EX_busy ? M_WAIT : (EX_branch_taken ? M_FLUSH : M_RUN);
        else if (EX_branch_taken)        nxt = M_FLUSH;
        else if (EX_busy)                nxt = M_WAIT;
        else if (f_load_use() && m_mode == M_RUN) nxt = M_LU;
        m_mode = nxt;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic busy, input logic br,
                         input logic e1, input logic [31:0] d1, input logic e2, input logic [31:0] d2);
        IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; ID_EX_rd = rd; ID_EX_memread = mr;
        EX_busy = busy; EX_branch_taken = br;
        fwd_rs1_enable = e1; fwd_rs1_data = d1;
        fwd_rs2_enable = e2; fwd_rs2_data = d2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2;
        check("reset PC_stall",      PC_stall, 0);
        check("reset EX_stall",      EX_stall, 0);
        check("reset flush",         IF_ID_flush, 0);
        check("reset hold_rs1_valid", hold_rs1_valid, 0);
        check("reset hold_rs2_data", hold_rs2_data, 0);
        check("reset stall_cycles",  stall_cycles, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use bubble, LU_BUBBLE blocks a repeat, then RUN bubbles again.
        drive(0, 5, 5, 1, 0, 0, 0, 0, 0, 0);
        sample();
        check("lu c0 bubble", ID_EX_bubble, 1);
        check("lu c0 PC_stall", PC_stall, 1);
        advance();
        sample();
        check("lu c1 bubble", ID_EX_bubble, 0);
        check("lu c1 PC_stall", PC_stall, 0);
        advance();
        sample();
        check("lu c2 bubble", ID_EX_bubble, 1);
        advance();
        idle();
        sample(); advance();
        sample(); advance();

        // Four-cycle EX_busy.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            sample();
            check("busy4 EX_stall", EX_stall, 1);
            advance();
        end
        idle();
        sample();
        check("busy4 EX_stall end", EX_stall, 0);
        check("busy4 stall_cycles", stall_cycles, CNT_ON ? 4 : 0);
        advance();

        // First forwarded operand wins until the stall ends.
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        sample(); advance();
        drive(0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF, 0, 0);
        sample(); advance();
        drive(0, 0, 0, 0, 1, 0, 1, 32'h12345678, 0, 0);
        sample();
        check("hold first data", hold_rs1_data, 32'hDEADBEEF);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("hold kept data", hold_rs1_data, 32'hDEADBEEF);
        check("hold kept valid", hold_rs1_valid, 1);
        advance();
        sample();
        check("hold cleared valid", hold_rs1_valid, 0);
        check("hold cleared data", hold_rs1_data, 0);
        advance();

        // Branch together with load-use.
        do_reset();
        drive(0, 5, 5, 1, 0, 1, 0, 0, 0, 0);
        sample();
        check("br c0 flush", IF_ID_flush, 1);
        check("br c0 bubble", ID_EX_bubble, 0);
        check("br c0 PC_stall", PC_stall, 0);
        advance();
        drive(0, 5, 5, 1, 0, 0, 0, 0, 0, 0);
        sample();
        check("br c1 flush", ID_EX_flush, 1);
        check("br c1 bubble", ID_EX_bubble, 0);
        advance();
        idle();
        sample();
        check("br c2 flush", IF_ID_flush, 0);
        advance();

        // Busy falls while branch resolves: flush next cycle, holds cleared.
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 1, 32'hA5A5A5A5, 1, 32'h5A5A5A5A);
        sample(); advance();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        sample(); advance();
        idle();
        sample();
        check("busyfall flush", IF_ID_flush, 1);
        check("busyfall rs2_valid", hold_rs2_valid, 0);
        advance();

        // Reset in the 2nd cycle of a 5-cycle busy.
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 1, 32'hCAFEF00D, 0, 0);
        sample(); advance();
        sample();
        check("prerst hold valid", hold_rs1_valid, 1);
        rst = 1'b1;
        #1;
        check("rst EX_stall", EX_stall, 0);
        check("rst PC_stall", PC_stall, 0);
        check("rst hold_rs1_valid", hold_rs1_valid, 0);
        check("rst hold_rs1_data", hold_rs1_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 7, 7, 1, 0, 0, 0, 0, 0, 0);
        sample();
        check("postrst bubble(RUN)", ID_EX_bubble, 1);
        advance();
        idle();
        sample(); advance();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                sample();
                advance();
            end
        end

        // Long continuous stall to exercise counter saturation.
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < LONG_RUN; i++) begin
            sample();
            advance();
        end
        sample();
        check("saturated stall_cycles", stall_cycles, CNT_ON ? 16'hFFFF : 16'h0000);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
